// File: rtl/banco_instrucoes_prog_if.sv
// banco_instrucoes_prog_if: fetch and program-load signals of the programmable instruction memory
interface banco_instrucoes_prog_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              fetch_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              addr_err;
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic              busy;
  modport master (
    output fetch_en, addr, load_start, load_valid, load_data, load_last,
    input  instr, instr_valid, addr_err, load_ready, load_done, busy
  );
  modport slave (
    input  fetch_en, addr, load_start, load_valid, load_data, load_last,
    output instr, instr_valid, addr_err, load_ready, load_done, busy
  );
endinterface

// File: rtl/banco_instrucoes_prog.sv
// banco_instrucoes_prog: run-time loadable instruction store, zeroed after reset, registered fetch port
module banco_instrucoes_prog #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 8
) (
  input logic clk_i,
  input logic rst_i,
  banco_instrucoes_prog_if.slave bus
);
  typedef enum logic [1:0] {CLEAR, RUN, LOAD} state_t;
  localparam int WP_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [WP_W-1:0] WP_LAST = WP_W'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);
  state_t state_q, state_d;
  logic [WP_W-1:0] wp_q, wp_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] instr_q, instr_d;
  logic instr_valid_q, instr_valid_d;
  logic addr_err_q, addr_err_d;
  logic load_done_q, load_done_d;
  logic in_range, fetch_ok, accept, wp_end, load_end;
  assign in_range = {1'b0, bus.addr} < DEPTH_A;
  assign fetch_ok = state_q == RUN && bus.fetch_en;
  assign accept   = state_q == LOAD && bus.load_valid;
  assign wp_end   = wp_q == WP_LAST;
  // a load ends on the marked word or when the last entry is written; wp never wraps
  assign load_end = accept && (bus.load_last || wp_end);
  always_comb begin
    state_d       = state_q;
    wp_d          = wp_q;
    instr_d       = fetch_ok ? (in_range ? mem[bus.addr[WP_W-1:0]] : '0) : instr_q;
    instr_valid_d = fetch_ok;
    addr_err_d    = fetch_ok && !in_range;
    load_done_d   = load_end;
    if (state_q == CLEAR) begin
      state_d = wp_end ? RUN : CLEAR;
      wp_d    = wp_end ? '0 : wp_q + 1'b1;
    end else if (state_q == RUN && bus.load_start) begin
      state_d = LOAD;
      wp_d    = '0;
    end else if (accept) begin
      state_d = load_end ? RUN : LOAD;
      wp_d    = load_end ? '0 : wp_q + 1'b1;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= CLEAR;
      wp_q          <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
      load_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wp_q          <= wp_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      addr_err_q    <= addr_err_d;
      load_done_q   <= load_done_d;
    end
  end
  // storage has no reset; CLEAR walks it to zero
  always_ff @(posedge clk_i) begin
    if (state_q == CLEAR || accept) mem[wp_q] <= state_q == LOAD ? bus.load_data : '0;
  end
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.addr_err    = addr_err_q;
  assign bus.load_done   = load_done_q;
  assign bus.load_ready  = state_q == LOAD;
  assign bus.busy        = state_q != RUN;
endmodule

// File: tb/tb_banco_instrucoes_prog.sv
// tb_banco_instrucoes_prog: directed vector bench for the programmable instruction memory
module tb_banco_instrucoes_prog;
  localparam int DW = 8, AW = 8, D = 8;
  typedef struct {
    logic       fe;
    logic [7:0] addr;
    logic [7:0] instr;
    logic       v;
    logic       err;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  vec_t vt [25];
  logic [7:0] w [8];
  always #5 clk = ~clk;
  banco_instrucoes_prog_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  banco_instrucoes_prog #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic run_vec(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.fetch_en = vt[i].fe;
      bus.addr     = vt[i].addr;
      step();
      chk($sformatf("vec%0d instr", i), bus.instr, vt[i].instr);
      chk($sformatf("vec%0d valid", i), bus.instr_valid, vt[i].v);
      chk($sformatf("vec%0d err", i), bus.addr_err, vt[i].err);
      chk($sformatf("vec%0d busy", i), bus.busy, 1'b0);
    end
    bus.fetch_en = 1'b0;
  endtask
  task automatic load_word(input logic [7:0] d, input logic last);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = last;
    step();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask
  task automatic clear_phase(input string n, input logic fe);
    for (int k = 0; k < D; k++) begin
      chk($sformatf("%s busy%0d", n, k), bus.busy, 1'b1);
      chk($sformatf("%s done%0d", n, k), bus.load_done, 1'b0);
      if (fe) chk($sformatf("%s valid%0d", n, k), bus.instr_valid, 1'b0);
      step();
    end
    chk({n, " busy end"}, bus.busy, 1'b0);
  endtask
  initial begin
    w = '{8'h11, 8'h2D, 8'h72, 8'h52, 8'h90, 8'hA1, 8'hC3, 8'hE0};
    for (int i = 0; i < 8; i++) vt[i] = '{1'b1, 8'(i), w[i], 1'b1, 1'b0};
    vt[8]  = '{1'b1, 8'd9,   8'h00, 1'b1, 1'b1};
    vt[9]  = '{1'b0, 8'd9,   8'h00, 1'b0, 1'b0};
    vt[10] = '{1'b1, 8'd7,   8'hE0, 1'b1, 1'b0};
    vt[11] = '{1'b0, 8'd0,   8'hE0, 1'b0, 1'b0};
    vt[12] = '{1'b1, 8'd0,   8'hFF, 1'b1, 1'b0};
    vt[13] = '{1'b1, 8'd1,   8'hEE, 1'b1, 1'b0};
    vt[14] = '{1'b1, 8'd2,   8'hDD, 1'b1, 1'b0};
    vt[15] = '{1'b1, 8'd3,   8'h52, 1'b1, 1'b0};
    vt[16] = '{1'b1, 8'hFF,  8'h00, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) vt[17 + i] = '{1'b1, 8'(i), 8'h00, 1'b1, 1'b0};
    bus.fetch_en = 1'b0; bus.addr = '0; bus.load_start = 1'b0;
    bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0;
    step();
    step();
    chk("rst instr", bus.instr, 8'h00);
    chk("rst valid", bus.instr_valid, 1'b0);
    chk("rst err", bus.addr_err, 1'b0);
    chk("rst done", bus.load_done, 1'b0);
    chk("rst ready", bus.load_ready, 1'b0);
    chk("rst busy", bus.busy, 1'b1);
    rst = 1'b0;
    bus.fetch_en = 1'b1;
    bus.addr = 8'd3;
    clear_phase("clr0", 1'b1);
    chk("clr0 last fetch ignored", bus.instr_valid, 1'b0);
    step();
    chk("first fetch instr", bus.instr, 8'h00);
    chk("first fetch valid", bus.instr_valid, 1'b1);
    chk("first fetch err", bus.addr_err, 1'b0);
    bus.fetch_en = 1'b0;
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    chk("load busy", bus.busy, 1'b1);
    chk("load ready", bus.load_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      load_word(w[i], 1'b0);
      chk($sformatf("full done%0d", i), bus.load_done, i == 7);
      chk($sformatf("full busy%0d", i), bus.busy, i != 7);
    end
    step();
    chk("full done drop", bus.load_done, 1'b0);
    run_vec(0, 11);
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    chk("reload ready", bus.load_ready, 1'b1);
    load_word(8'hFF, 1'b0);
    chk("reload done w0", bus.load_done, 1'b0);
    bus.load_data = 8'h77;
    bus.load_last = 1'b1;
    step();
    bus.load_last = 1'b0;
    chk("gap busy", bus.busy, 1'b1);
    chk("gap done", bus.load_done, 1'b0);
    load_word(8'hEE, 1'b0);
    chk("reload done w1", bus.load_done, 1'b0);
    load_word(8'hDD, 1'b1);
    chk("reload done w2", bus.load_done, 1'b1);
    chk("reload busy w2", bus.busy, 1'b0);
    chk("reload ready w2", bus.load_ready, 1'b0);
    step();
    chk("reload done drop", bus.load_done, 1'b0);
    run_vec(12, 16);
    bus.fetch_en = 1'b1;
    bus.addr = 8'd4;
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    chk("fetch+start instr", bus.instr, 8'h90);
    chk("fetch+start valid", bus.instr_valid, 1'b1);
    chk("fetch+start busy", bus.busy, 1'b1);
    bus.addr = 8'd0;
    step();
    chk("load fetch valid", bus.instr_valid, 1'b0);
    chk("load fetch instr", bus.instr, 8'h90);
    chk("load fetch err", bus.addr_err, 1'b0);
    bus.fetch_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load_word(8'(i + 1), 1'b0);
      chk($sformatf("part done%0d", i), bus.load_done, 1'b0);
    end
    rst = 1'b1;
    #1;
    chk("midload rst busy", bus.busy, 1'b1);
    chk("midload rst instr", bus.instr, 8'h00);
    chk("midload rst ready", bus.load_ready, 1'b0);
    step();
    rst = 1'b0;
    clear_phase("clr1", 1'b0);
    run_vec(17, 24);
    chk("final done", bus.load_done, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
